// File: rtl/conv_l1_pkg.sv
// Shared types and constants for the first-layer convolution controller.
// Also provides the per-frame result count used by the controller's users.
package conv_l1_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_LAST   = 2'd3
  } ctrl_state_e;

  localparam int KERNEL_TAPS = 9;
  localparam int WIN         = 3;
  localparam int KIDX_W      = 4;

  // Only windows that fit entirely inside the frame produce a result.
  function automatic int results_per_frame(input int img_w, input int img_h);
    return (img_w - WIN + 1) * (img_h - WIN + 1);
  endfunction

endpackage

// File: rtl/conv_l1_ctrl_raster_counter.sv
// Raster-order row/column position counter with enable, clear, wrap and
// first/last-of-frame flags.
module raster_counter #(
  parameter int W  = 28,
  parameter int H  = 28,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic          first_o,
  output logic          last_o
);

  localparam logic [CW-1:0] COL_MAX = CW'(W - 1);
  localparam logic [CW-1:0] ROW_MAX = CW'(H - 1);

  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  // next position: clear has priority, otherwise step in raster order
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (en_i) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        if (row_q == ROW_MAX) begin
          row_d = '0;
        end else begin
          row_d = row_q + CW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
        row_d = row_q;
      end
    end else begin
      row_d = row_q;
      col_d = col_q;
    end
  end

  // position registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o   = row_q;
  assign col_o   = col_q;
  assign first_o = (row_q == '0) && (col_q == '0);
  assign last_o  = (row_q == ROW_MAX) && (col_q == COL_MAX);

endmodule

// File: rtl/conv_l1_ctrl.sv
// Sequencer for the 3x3 first-layer convolution datapath: kernel load,
// pixel stream pacing and qualification of complete output windows.
module conv_l1_ctrl
  import conv_l1_pkg::*;
#(
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int COORD_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 k_wr_en,
  input  logic [7:0]           k_wr_data,
  output logic [71:0]          kernel_flat,
  input  logic                 start,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [7:0]           s_data,
  output logic [7:0]           dp_pxl,
  output logic                 dp_en,
  input  logic [15:0]          dp_result,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [15:0]          m_data,
  output logic [COORD_W-1:0]   m_row,
  output logic [COORD_W-1:0]   m_col,
  output logic                 m_last,
  output logic                 busy,
  output logic                 done
);

  localparam logic [COORD_W-1:0] WIN_OFS  = COORD_W'(WIN - 1);
  localparam logic [KIDX_W-1:0]  KIDX_MAX = KIDX_W'(KERNEL_TAPS - 1);

  ctrl_state_e state_q, state_d;

  logic [KERNEL_TAPS-1:0][7:0] kernel_q, kernel_d;
  logic [KIDX_W-1:0]           k_idx_q, k_idx_d;
  logic                        m_valid_q, m_valid_d;
  logic                        m_last_q, m_last_d;
  logic [COORD_W-1:0]          m_row_q, m_row_d;
  logic [COORD_W-1:0]          m_col_q, m_col_d;
  logic                        done_q, done_d;

  logic [COORD_W-1:0] row_s, col_s;
  logic               last_beat_s;
  logic               frame_first_unused;
  logic               clr_s;
  logic               qualify_s;

  assign clr_s = (state_q == S_IDLE) && start && !k_wr_en;

  raster_counter #(
    .W  (IMG_W),
    .H  (IMG_H),
    .CW (COORD_W)
  ) u_raster (
    .clk     (clk),
    .rst_n   (reset),
    .clr_i   (clr_s),
    .en_i    (dp_en),
    .row_o   (row_s),
    .col_o   (col_s),
    .first_o (frame_first_unused),
    .last_o  (last_beat_s)
  );

  assign s_ready = (state_q == S_STREAM) && (!m_valid_q || m_ready);
  assign dp_en   = s_valid && s_ready;
  assign dp_pxl  = s_data;

  // Beats with row<2 or col<2 carry wrapped or stale windows and are dropped.
  assign qualify_s = dp_en && (row_s >= WIN_OFS) && (col_s >= WIN_OFS);

  // control FSM and kernel register file
  always_comb begin
    state_d  = state_q;
    kernel_d = kernel_q;
    k_idx_d  = k_idx_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (k_wr_en) begin
          kernel_d[0] = k_wr_data;
          k_idx_d     = KIDX_W'(1);
          state_d     = S_LOAD;
        end else if (start) begin
          state_d = S_STREAM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (k_wr_en) begin
          kernel_d[k_idx_q] = k_wr_data;
          if (k_idx_q == KIDX_MAX) begin
            k_idx_d = '0;
            state_d = S_IDLE;
          end else begin
            k_idx_d = k_idx_q + KIDX_W'(1);
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_STREAM: begin
        if (dp_en && last_beat_s) begin
          state_d = S_LAST;
        end else begin
          state_d = S_STREAM;
        end
      end
      S_LAST: begin
        if (m_valid_q && m_ready) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_LAST;
        end
      end
      default: begin
        state_d = S_IDLE;
        k_idx_d = '0;
      end
    endcase
  end

  // result qualification and tagging
  always_comb begin
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_row_d   = m_row_q;
    m_col_d   = m_col_q;
    if (qualify_s) begin
      m_valid_d = 1'b1;
      m_row_d   = row_s - WIN_OFS;
      m_col_d   = col_s - WIN_OFS;
      m_last_d  = last_beat_s;
    end else if (dp_en) begin
      m_valid_d = 1'b0;
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  // state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      kernel_q  <= '0;
      k_idx_q   <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_row_q   <= '0;
      m_col_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      kernel_q  <= kernel_d;
      k_idx_q   <= k_idx_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_row_q   <= m_row_d;
      m_col_q   <= m_col_d;
      done_q    <= done_d;
    end
  end

  assign kernel_flat = kernel_q;
  assign m_valid     = m_valid_q;
  assign m_data      = dp_result;
  assign m_row       = m_row_q;
  assign m_col       = m_col_q;
  assign m_last      = m_last_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;

endmodule

// File: tb/tb_conv_l1_ctrl.sv
// Bench for conv_l1_ctrl on a 5x5 frame with a behavioural 3x3 datapath
// advanced by dp_en; pixel p(r,c) = 5r + c.
module tb_conv_l1_ctrl;

  localparam int W  = 5;
  localparam int H  = 5;
  localparam int CW = 3;

  typedef struct {
    logic [15:0] data;
    int          row;
    int          col;
    bit          last;
  } res_t;

  typedef struct {
    bit         we;
    bit         st;
    logic [7:0] wd;
    bit         exp_busy;
    bit         exp_sready;
  } ctl_vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          k_wr_en;
  logic [7:0]    k_wr_data;
  logic [71:0]   kernel_flat;
  logic          start;
  logic          s_valid;
  logic          s_ready;
  logic [7:0]    s_data;
  logic [7:0]    dp_pxl;
  logic          dp_en;
  logic [15:0]   dp_result;
  logic          m_valid;
  logic          m_ready;
  logic [15:0]   m_data;
  logic [CW-1:0] m_row;
  logic [CW-1:0] m_col;
  logic          m_last;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  res_t got [16];
  int   n_got;
  int   first_pix;

  res_t     tbl_id  [9];
  res_t     tbl_one [9];
  ctl_vec_t ctl_tbl [10];

  localparam logic [71:0] K_ID   = 72'h00_00_00_00_01_00_00_00_00;
  localparam logic [71:0] K_ONES = 72'h01_01_01_01_01_01_01_01_01;

  always #5 clk = ~clk;

  conv_l1_ctrl #(.IMG_W(W), .IMG_H(H), .COORD_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .k_wr_en     (k_wr_en),
    .k_wr_data   (k_wr_data),
    .kernel_flat (kernel_flat),
    .start       (start),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .dp_pxl      (dp_pxl),
    .dp_en       (dp_en),
    .dp_result   (dp_result),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_row       (m_row),
    .m_col       (m_col),
    .m_last      (m_last),
    .busy        (busy),
    .done        (done)
  );

  // Behavioural datapath: history of the last 2W+3 pixels, window over it.
  logic [7:0] hist [13] = '{default: 8'd0};

  always @(posedge clk) begin
    if (dp_en) begin
      for (int i = 12; i > 0; i--) hist[i] <= hist[i-1];
      hist[0] <= dp_pxl;
    end
  end

  always_comb begin
    dp_result = 16'd0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        dp_result = dp_result + 16'(kernel_flat[8*(3*i+j) +: 8]) * 16'(hist[(2-i)*W + (2-j)]);
      end
    end
  end

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_kernel(input logic [71:0] kv);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      k_wr_en   = 1'b1;
      k_wr_data = kv[8*i +: 8];
    end
    @(negedge clk);
    k_wr_en = 1'b0;
    check("kernel_loaded", kernel_flat, kv);
    check("idle_after_load", busy, 1'b0);
  endtask

  task automatic run_frame(input bit toggle, input int stall_at, input logic [15:0] stall_data,
                           input bit poke);
    int pix, cyc, stall_cnt;
    bit fin;
    pix = 0; cyc = 0; stall_cnt = 0; fin = 1'b0;
    n_got = 0; first_pix = -1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    while (!fin && cyc < 300) begin
      k_wr_en   = poke && (cyc == 3);
      k_wr_data = 8'hAA;
      s_valid   = (pix < W*H) && (!toggle || (cyc % 2 == 0));
      s_data    = 8'(pix);
      if (m_valid && n_got == stall_at && stall_cnt < 4) begin
        m_ready = 1'b0;
        stall_cnt++;
      end else begin
        m_ready = 1'b1;
      end
      #1;
      if (!m_ready) begin
        check("stall_s_ready", s_ready, 1'b0);
        check("stall_dp_en", dp_en, 1'b0);
        check("stall_m_data", m_data, stall_data);
      end
      if (m_valid && m_ready) begin
        if (n_got == 0) first_pix = pix;
        if (n_got < 16) got[n_got] = '{m_data, int'(m_row), int'(m_col), m_last};
        n_got++;
        if (m_last) fin = 1'b1;
      end
      if (s_valid && s_ready) pix++;
      @(negedge clk);
      cyc++;
    end
    k_wr_en = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    if (!fin) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_timeout: got %0d results, required last result within 300 cycles", n_got);
    end
    check("done_pulse", done, 1'b1);
    check("busy_after_frame", busy, 1'b0);
    @(negedge clk);
    check("done_clear", done, 1'b0);
    if (stall_at >= 0) check("stall_cycles", stall_cnt, 4);
  endtask

  task automatic compare_frame(input res_t t [9], input string tag);
    check({tag, "_count"}, n_got, 9);
    check({tag, "_first_pix"}, first_pix, 13);
    for (int i = 0; i < 9 && i < n_got; i++) begin
      check($sformatf("%s[%0d].data", tag, i), got[i].data, t[i].data);
      check($sformatf("%s[%0d].row", tag, i), got[i].row, t[i].row);
      check($sformatf("%s[%0d].col", tag, i), got[i].col, t[i].col);
      check($sformatf("%s[%0d].last", tag, i), got[i].last, t[i].last);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  initial begin
    tbl_id[0] = '{16'd6,  0, 0, 1'b0};
    tbl_id[1] = '{16'd7,  0, 1, 1'b0};
    tbl_id[2] = '{16'd8,  0, 2, 1'b0};
    tbl_id[3] = '{16'd11, 1, 0, 1'b0};
    tbl_id[4] = '{16'd12, 1, 1, 1'b0};
    tbl_id[5] = '{16'd13, 1, 2, 1'b0};
    tbl_id[6] = '{16'd16, 2, 0, 1'b0};
    tbl_id[7] = '{16'd17, 2, 1, 1'b0};
    tbl_id[8] = '{16'd18, 2, 2, 1'b1};

    tbl_one[0] = '{16'd54,  0, 0, 1'b0};
    tbl_one[1] = '{16'd63,  0, 1, 1'b0};
    tbl_one[2] = '{16'd72,  0, 2, 1'b0};
    tbl_one[3] = '{16'd99,  1, 0, 1'b0};
    tbl_one[4] = '{16'd108, 1, 1, 1'b0};
    tbl_one[5] = '{16'd117, 1, 2, 1'b0};
    tbl_one[6] = '{16'd144, 2, 0, 1'b0};
    tbl_one[7] = '{16'd153, 2, 1, 1'b0};
    tbl_one[8] = '{16'd162, 2, 2, 1'b1};

    ctl_tbl[0] = '{1'b1, 1'b1, 8'h11, 1'b1, 1'b0};
    ctl_tbl[1] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    ctl_tbl[2] = '{1'b1, 1'b0, 8'h21, 1'b1, 1'b0};
    ctl_tbl[3] = '{1'b1, 1'b0, 8'h22, 1'b1, 1'b0};
    ctl_tbl[4] = '{1'b1, 1'b0, 8'h23, 1'b1, 1'b0};
    ctl_tbl[5] = '{1'b1, 1'b0, 8'h24, 1'b1, 1'b0};
    ctl_tbl[6] = '{1'b1, 1'b0, 8'h25, 1'b1, 1'b0};
    ctl_tbl[7] = '{1'b1, 1'b0, 8'h26, 1'b1, 1'b0};
    ctl_tbl[8] = '{1'b1, 1'b0, 8'h27, 1'b1, 1'b0};
    ctl_tbl[9] = '{1'b1, 1'b0, 8'h28, 1'b0, 1'b0};

    reset = 1'b0; k_wr_en = 1'b0; k_wr_data = 8'd0; start = 1'b0;
    s_valid = 1'b0; s_data = 8'd0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_kernel", kernel_flat, 72'd0);
    check("rst_done", done, 1'b0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_m_row", m_row, 3'd0);
    check("rst_m_col", m_col, 3'd0);
    check("rst_s_ready", s_ready, 1'b0);

    // identity kernel
    load_kernel(K_ID);
    run_frame(1'b0, -1, 16'd0, 1'b0);
    compare_frame(tbl_id, "ident");

    // all-ones kernel
    load_kernel(K_ONES);
    run_frame(1'b0, -1, 16'd0, 1'b0);
    compare_frame(tbl_one, "ones");

    // consumer stall on the third result
    load_kernel(K_ID);
    run_frame(1'b0, 2, 16'd8, 1'b0);
    compare_frame(tbl_id, "stall");

    // gapped input stream
    run_frame(1'b1, -1, 16'd0, 1'b0);
    compare_frame(tbl_id, "toggle");

    // coefficient write attempted mid-frame
    run_frame(1'b0, -1, 16'd0, 1'b1);
    compare_frame(tbl_id, "poke");
    check("kernel_stable_in_stream", kernel_flat, K_ID);

    // write beats start in IDLE; start ignored in LOAD
    for (int i = 0; i < 10; i++) begin
      k_wr_en   = ctl_tbl[i].we;
      start     = ctl_tbl[i].st;
      k_wr_data = ctl_tbl[i].wd;
      @(negedge clk);
      check($sformatf("ctl[%0d].busy", i), busy, ctl_tbl[i].exp_busy);
      check($sformatf("ctl[%0d].s_ready", i), s_ready, ctl_tbl[i].exp_sready);
    end
    k_wr_en = 1'b0;
    start   = 1'b0;
    @(negedge clk);
    check("ctl_no_frame", busy, 1'b0);
    check("ctl_kernel", kernel_flat, 72'h28_27_26_25_24_23_22_21_11);

    // asynchronous reset at the 14th pixel
    load_kernel(K_ID);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int pix = 0;
      int cyc = 0;
      while (pix < 13 && cyc < 100) begin
        s_valid = 1'b1;
        s_data  = 8'(pix);
        #1;
        if (s_ready) pix++;
        @(negedge clk);
        cyc++;
      end
      check("pre_reset_pixels", pix, 13);
    end
    check("pre_reset_m_valid", m_valid, 1'b1);
    check("pre_reset_m_data", m_data, 16'd6);
    s_valid = 1'b1;
    s_data  = 8'd13;
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_m_valid", m_valid, 1'b0);
    check("async_rst_kernel", kernel_flat, 72'd0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_s_ready", s_ready, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    reset   = 1'b1;
    load_kernel(K_ID);
    run_frame(1'b0, -1, 16'd0, 1'b0);
    compare_frame(tbl_id, "after_rst");

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
